// File: rtl/spi_sram_responder.sv
// ============================================================================
// Module   : spi_sram_responder
// Purpose  : SPI mode-0 slave that emulates a sequential-mode serial SRAM
//            with 24-bit addressing (READ 0x03, WRITE 0x02, RDMR 0x05,
//            WRMR 0x01). Data lives in an internal byte array of
//            2**ADDR_WIDTH bytes; a registered backdoor port reads it
//            without any SPI traffic.
// Ports    : clk_i/rst_i          system clock, synchronous active-high reset
//            spi_ss_n/sck/mosi   asynchronous SPI inputs (2-FF synchronised)
//            spi_miso/_oe        serial data out and its output enable
//            active_o            transaction in progress (state not IDLE)
//            cmd_err_o           1-cycle pulse on an unsupported command
//            bd_adr_i/bd_dat_o   backdoor read, 1-cycle latency
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sram_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [7:0]  MODE_REG   = 8'h40
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spi_ss_n,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic                  active_o,
    output logic                  cmd_err_o,
    input  logic [ADDR_WIDTH-1:0] bd_adr_i,
    output logic [7:0]            bd_dat_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // Only the bits that can ever matter are kept: the command byte needs 8,
    // the address needs ADDR_WIDTH; higher address bits are shifted out.
    localparam int SHW   = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_READ, S_WRITE, S_RDMR, S_WRMR, S_IGNORE
    } state_t;

    // Synchronisers and SCK edge detect
    logic ss_meta_q, ss_s_q, sck_meta_q, sck_s_q, sck_d_q, mosi_meta_q, mosi_s_q;
    logic w_rise, w_fall;

    state_t                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;     // rise counter (cmd/addr/write)
    logic [2:0]            fcnt_q, fcnt_d;   // fall counter (read/rdmr)
    logic [SHW-2:0]        sh_q, sh_d;
    logic [SHW-1:0]        w_shift;
    logic [7:0]            tx_q, tx_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  is_rd_q, is_rd_d;
    logic                  fetch_q, fetch_d;
    logic                  miso_q, miso_d;
    logic                  oe_q, oe_d;
    logic                  err_q, err_d;
    logic                  block_q, block_d; // set by reset until ss_n seen high
    logic                  w_we;
    logic [7:0]            w_rd_byte;
    logic [7:0]            bd_q;
    logic [7:0]            mem_q [DEPTH];

    assign w_rise    = sck_s_q & ~sck_d_q;
    assign w_fall    = ~sck_s_q & sck_d_q;
    assign w_shift   = {sh_q, mosi_s_q};
    assign w_rd_byte = mem_q[ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // ss_n synchroniser resets to "selected" so block_q only clears
            // once a genuine deselect has been observed.
            ss_meta_q   <= 1'b0;
            ss_s_q      <= 1'b0;
            sck_meta_q  <= 1'b0;
            sck_s_q     <= 1'b0;
            sck_d_q     <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_s_q    <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            fcnt_q      <= '0;
            sh_q        <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            is_rd_q     <= 1'b0;
            fetch_q     <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            err_q       <= 1'b0;
            block_q     <= 1'b1;
            bd_q        <= '0;
        end else begin
            ss_meta_q   <= spi_ss_n;
            ss_s_q      <= ss_meta_q;
            sck_meta_q  <= spi_sck;
            sck_s_q     <= sck_meta_q;
            sck_d_q     <= sck_s_q;
            mosi_meta_q <= spi_mosi;
            mosi_s_q    <= mosi_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fcnt_q      <= fcnt_d;
            sh_q        <= sh_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            is_rd_q     <= is_rd_d;
            fetch_q     <= fetch_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            err_q       <= err_d;
            block_q     <= block_d;
            bd_q        <= mem_q[bd_adr_i];
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_we && !rst_i) begin
            mem_q[ptr_q] <= w_shift[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        ptr_d   = ptr_q;
        is_rd_d = is_rd_q;
        fetch_d = 1'b0;
        miso_d  = miso_q;
        oe_d    = oe_q;
        err_d   = 1'b0;
        block_d = block_q;
        w_we    = 1'b0;

        if (ss_s_q) begin
            // Deselect overrides everything; a partial byte is dropped.
            state_d = S_IDLE;
            cnt_d   = '0;
            fcnt_d  = '0;
            sh_d    = '0;
            miso_d  = 1'b0;
            oe_d    = 1'b0;
            block_d = 1'b0;
        end else if (block_q) begin
            state_d = S_IDLE;
            miso_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    fcnt_d  = '0;
                end
                S_CMD: begin
                    if (w_rise) begin
                        sh_d  = w_shift[SHW-2:0];
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d = '0;
                            case (w_shift[7:0])
                                8'h03: begin state_d = S_ADDR; is_rd_d = 1'b1; end
                                8'h02: begin state_d = S_ADDR; is_rd_d = 1'b0; end
                                8'h05:       state_d = S_RDMR;
                                8'h01:       state_d = S_WRMR;
                                default: begin state_d = S_IGNORE; err_d = 1'b1; end
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (w_rise) begin
                        sh_d  = w_shift[SHW-2:0];
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd23) begin
                            cnt_d = '0;
                            ptr_d = w_shift[ADDR_WIDTH-1:0];
                            if (is_rd_q) begin
                                state_d = S_READ;
                                fetch_d = 1'b1;
                            end else begin
                                state_d = S_WRITE;
                            end
                        end
                    end
                end
                S_READ: begin
                    // Fetch runs one cycle after the last address rise or
                    // the 8th fall, well before the next fall arrives.
                    if (fetch_q) begin
                        tx_d  = w_rd_byte;
                        ptr_d = ptr_q + 1'b1;
                    end
                    if (w_fall) begin
                        miso_d = tx_q[7];
                        oe_d   = 1'b1;
                        tx_d   = {tx_q[6:0], 1'b0};
                        fcnt_d = fcnt_q + 3'd1;
                        if (fcnt_q == 3'd7) begin
                            fetch_d = 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_rise) begin
                        sh_d  = w_shift[SHW-2:0];
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d = '0;
                            w_we  = 1'b1;
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                end
                S_RDMR: begin
                    if (w_fall) begin
                        miso_d = MODE_REG[3'd7 - fcnt_q];
                        oe_d   = 1'b1;
                        fcnt_d = fcnt_q + 3'd1;
                    end
                end
                S_WRMR: begin
                    if (w_rise) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d   = '0;
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_IGNORE: begin
                    miso_d = 1'b0;
                    oe_d   = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q & ~ss_s_q;
    assign active_o    = (state_q != S_IDLE);
    assign cmd_err_o   = err_q;
    assign bd_dat_o    = bd_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_sram_responder.sv
// ============================================================================
// Module   : tb_spi_sram_responder
// Purpose  : Self-checking bench for spi_sram_responder. Stimulus tasks act
//            as an SPI master and push expected MISO bytes into a queue; an
//            independent monitor reassembles MISO frames on SCK rises and
//            compares them against that queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_sram_responder;

    localparam int AW   = 10;
    localparam int HALF = 8;   // SCK half period in clk cycles

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ss_n = 1'b1;
    logic          sck = 1'b0;
    logic          mosi = 1'b0;
    logic [AW-1:0] bd_adr = '0;
    logic          miso, miso_oe, active, cmd_err;
    logic [7:0]    bd_dat;

    spi_sram_responder #(.ADDR_WIDTH(AW), .MODE_REG(8'h40)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .spi_ss_n    (ss_n),
        .spi_sck     (sck),
        .spi_mosi    (mosi),
        .spi_miso    (miso),
        .spi_miso_oe (miso_oe),
        .active_o    (active),
        .cmd_err_o   (cmd_err),
        .bd_adr_i    (bd_adr),
        .bd_dat_o    (bd_dat)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] model [0:(1<<AW)-1];   // reference memory image
    logic [7:0] exp_q [$];             // expected MISO data bytes
    logic [7:0] wq [$];                // payload for the next write
    int         err_pulses = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endfunction

    always @(negedge clk) if (cmd_err === 1'b1) err_pulses++;

    // ---------------- monitor: frames MISO on SCK rises ----------------
    int         mon_bits = 0;
    logic [7:0] mon_fr;
    bit         mon_any_oe, mon_all_oe;
    always @(posedge sck or posedge ss_n) begin
        if (ss_n) begin
            mon_bits = 0;   // partial frames are discarded
        end else begin
            if (mon_bits == 0) begin
                mon_any_oe = 1'b0;
                mon_all_oe = 1'b1;
            end
            mon_fr     = {mon_fr[6:0], miso};
            mon_any_oe = mon_any_oe | (miso_oe === 1'b1);
            mon_all_oe = mon_all_oe & (miso_oe === 1'b1);
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (mon_any_oe) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_oe_frame", {24'd0, mon_fr}, 32'hFFFF_FFFF);
                    end else begin
                        check("miso_byte", {24'd0, mon_fr}, {24'd0, exp_q.pop_front()});
                        check("oe_whole_byte", {31'd0, mon_all_oe}, 32'd1);
                    end
                end else begin
                    check("miso_idle_zero", {24'd0, mon_fr}, 32'd0);
                end
            end
        end
    end

    // ---------------- SPI master tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b);
        mosi = b;
        wait_clk(HALF);
        sck = 1'b1;
        wait_clk(HALF);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) spi_bit(v[i]);
    endtask

    task automatic begin_tx();
        @(negedge clk);
        ss_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic end_tx(input bit chk_active);
        int n;
        wait_clk(HALF);
        ss_n = 1'b1;
        if (chk_active) begin
            n = 0;
            while (n < 10) begin
                @(posedge clk);
                #1;
                n++;
                if (active === 1'b0) break;
            end
            check("active_fall_cycles", n, 3);
        end
        wait_clk(3 * HALF);
    endtask

    task automatic send_addr(input logic [23:0] a);
        spi_byte(a[23:16]);
        spi_byte(a[15:8]);
        spi_byte(a[7:0]);
    endtask

    // Writes the bytes in wq starting at address a and updates the model.
    task automatic write_tx(input logic [23:0] a, input bit chk_active);
        logic [AW-1:0] idx;
        begin_tx();
        spi_byte(8'h02);
        send_addr(a);
        for (int k = 0; k < wq.size(); k++) begin
            spi_byte(wq[k]);
            idx        = a[AW-1:0] + AW'(k);
            model[idx] = wq[k];
        end
        end_tx(chk_active);
    endtask

    task automatic read_tx(input logic [23:0] a, input int n);
        logic [AW-1:0] idx;
        begin_tx();
        spi_byte(8'h03);
        send_addr(a);
        for (int k = 0; k < n; k++) begin
            idx = a[AW-1:0] + AW'(k);
            exp_q.push_back(model[idx]);
            spi_byte(8'($urandom));
        end
        end_tx(1'b0);
    endtask

    task automatic bd_check(input logic [AW-1:0] a, input logic [7:0] req);
        @(negedge clk);
        bd_adr = a;
        @(posedge clk);
        #1;
        check("backdoor", {24'd0, bd_dat}, {24'd0, req});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [23:0] a, ra;
        int          len, e0;

        wait_clk(5);
        check("rst_miso", {31'd0, miso}, 0);
        check("rst_oe", {31'd0, miso_oe}, 0);
        check("rst_active", {31'd0, active}, 0);
        check("rst_cmd_err", {31'd0, cmd_err}, 0);
        check("rst_bd_dat", {24'd0, bd_dat}, 0);
        rst = 1'b0;
        wait_clk(5);

        // Basic write then read back
        wq = '{8'hA5, 8'h3C};
        write_tx(24'h000010, 1'b1);
        bd_check(10'h010, 8'hA5);
        bd_check(10'h011, 8'h3C);
        read_tx(24'h000010, 2);

        // Pointer wrap and upper-address aliasing
        wq = '{8'h11, 8'h22};
        write_tx(24'h0003FF, 1'b0);
        bd_check(10'h3FF, 8'h11);
        bd_check(10'h000, 8'h22);
        read_tx(24'hFF03FF, 2);

        // Partial trailing byte is discarded
        wq = '{8'h5A};
        write_tx(24'h000021, 1'b0);
        begin_tx();
        spi_byte(8'h02);
        send_addr(24'h000020);
        spi_byte(8'hFF);
        model[10'h020] = 8'hFF;
        for (int i = 0; i < 5; i++) spi_bit(1'b1);
        end_tx(1'b0);
        bd_check(10'h020, 8'hFF);
        bd_check(10'h021, 8'h5A);
        read_tx(24'h000020, 2);
        check("no_err_yet", err_pulses, 0);

        // Unsupported command: one error pulse, MISO silent afterwards
        e0 = err_pulses;
        begin_tx();
        spi_byte(8'h9F);
        spi_byte(8'($urandom));
        spi_byte(8'($urandom));
        end_tx(1'b0);
        check("cmd_err_pulses", err_pulses - e0, 1);

        // Mode register read repeats every byte
        begin_tx();
        spi_byte(8'h05);
        exp_q.push_back(8'h40);
        spi_byte(8'h00);
        exp_q.push_back(8'h40);
        spi_byte(8'h00);
        end_tx(1'b0);

        // Randomised write/read-back with aliased upper address bits
        for (int t = 0; t < 12; t++) begin
            wq.delete();
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) wq.push_back(8'($urandom));
            a = 24'($urandom);
            write_tx(a, 1'b0);
            bd_check(a[AW-1:0], model[a[AW-1:0]]);
            ra = (24'($urandom) & 24'hFFFC00) | {14'd0, a[AW-1:0]};
            read_tx(ra, len);
        end

        // Reset in the middle of a read with ss_n still low
        begin_tx();
        spi_byte(8'h03);
        send_addr(24'h000010);
        exp_q.push_back(model[10'h010]);
        spi_byte(8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            spi_bit(1'b1);
            check("post_rst_quiet", {28'd0, miso, miso_oe, active, cmd_err}, 0);
        end
        end_tx(1'b0);
        read_tx(24'h000010, 2);

        wait_clk(10);
        check("exp_queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_sram_responder.md
Name: spi_sram_responder

Overview:
- SPI-mode-0 slave that emulates a serial SRAM: sequential mode, 24-bit addressing, 23LC1024-style command set.
- It is the device-side counterpart of spi_controller; it answers the controller's READ/WRITE transactions from an internal byte array.
- Used as the on-chip/bench memory model behind the spi_controller pins (uio sck/mosi/ss_n/miso) and as a loopback target for bring-up.
- A backdoor read port lets benches inspect memory contents without SPI traffic.

Parameters:
- ADDR_WIDTH, 10, memory address bits. Memory holds DEPTH = 2**ADDR_WIDTH bytes; upper address bits received over SPI are ignored.
- MODE_REG, 8'h40, value returned by RDMR (sequential mode). Fixed; writes via WRMR are accepted and discarded.

Ports:
- clk_i  input  1  system clock; must run at least 4x the SCK frequency
- rst_i  input  1  synchronous active-high reset
- spi_ss_n  input  1  chip select, active low, asynchronous to clk_i
- spi_sck  input  1  serial clock, mode 0, asynchronous
- spi_mosi  input  1  serial data in
- spi_miso  output  1  serial data out
- spi_miso_oe  output  1  high while the slave drives spi_miso
- active_o  output  1  high while a transaction is in progress (state not IDLE)
- cmd_err_o  output  1  one-cycle pulse when an unsupported command byte completes
- bd_adr_i  input  ADDR_WIDTH  backdoor read address
- bd_dat_o  output  8  backdoor read data, registered, 1-cycle latency

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, active_o=0, cmd_err_o=0, bd_dat_o=0, state=IDLE. Memory contents are not reset.
- Synchronisation:
  - ss_n, sck and mosi each pass through a 2-FF synchroniser.
  - A third register on sck gives edge detect: rise = sck_s & ~sck_d; fall = ~sck_s & sck_d.
  - mosi is sampled from its synchronised copy on the rise cycle.
- Chip select:
  - When synchronised ss_n is high, state is forced to IDLE in the same cycle and bit counter and shift register are cleared. This overrides any edge.
  - spi_miso_oe drops in the cycle ss_n_s goes high.
  - A partial data byte (fewer than 8 bits) is discarded and never written.
- States:
  - IDLE -> CMD on ss_n_s low.
  - CMD: shift 8 bits MSB first. On the 8th rise, decode:
    - 0x03 -> ADDR (read)
    - 0x02 -> ADDR (write)
    - 0x05 -> RDMR
    - 0x01 -> WRMR
    - any other value -> IGNORE, and pulse cmd_err_o.
  - ADDR: shift 24 bits MSB first. On the 24th rise, latch the low ADDR_WIDTH bits into the address pointer, then go to READ or WRITE.
  - READ:
    - In the cycle after the 24th address rise, fetch mem[ptr] into the tx shift register and increment ptr.
    - On each fall, drive spi_miso with the next bit, MSB first, and set spi_miso_oe=1.
    - After the 8th fall of a byte, load the next byte from mem[ptr] and increment ptr. This fetch is pipelined so MISO is valid before the following fall.
  - WRITE: shift 8 bits. On the 8th rise, write mem[ptr] <= byte and increment ptr.
  - RDMR: shift out MODE_REG on falls; repeats every 8 bits.
  - WRMR: consume 8 bits and discard them; then IGNORE.
  - IGNORE: spi_miso=0, spi_miso_oe=0 until ss_n_s goes high.
- Pointer wraps modulo DEPTH: ptr DEPTH-1 -> 0. Upper address bits received over SPI have no effect.
- Read and write transactions have unlimited length.
- Only one SPI write per byte period, so no backdoor/SPI write conflict. The backdoor read port is independent and has priority-free dual access.
- bd_dat_o <= mem[bd_adr_i] every cycle. It reflects an SPI write in the same cycle as read-after-write only from the next cycle onward.
- Reset asserted mid-transaction: return to IDLE and hold outputs at reset values until ss_n_s is seen high and then low again. Memory is unchanged.
- Target size: about 200-300 lines of RTL.

Test Plan:
- Write 0x02, addr 0x000010, data A5 3C -> bd_dat_o at 0x010=0xA5 and at 0x011=0x3C; active_o falls 3 cycles after ss_n rises.
- Read 0x03, addr 0x000010, clock 16 data bits -> MISO returns 0xA5 then 0x3C; spi_miso_oe=1 only during data bits.
- Wrap-around:
  - Write at addr 0x0003FF with bytes 11 22 (ADDR_WIDTH=10) -> mem[0x3FF]=0x11, mem[0x000]=0x22.
  - Addr 0xFF03FF aliases to the same location.
- Partial byte: write 0x02, addr 0x20, data 0xFF then 5 bits, raise ss_n -> mem[0x20]=0xFF, mem[0x21] unchanged; next transaction starts cleanly in CMD.
- Command 0x9F -> cmd_err_o pulses exactly once, MISO stays 0 and oe stays 0 for the remainder; RDMR 0x05 -> reads 0x40 0x40.
- rst_i pulsed mid-read with ss_n low -> all outputs 0 until ss_n toggles; a subsequent read returns the previously written data.
